// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: state encodings and fetch constants.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_t;

   localparam int unsigned PC_INC    = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO holding fetched {instr, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] push_instr,
   input  logic [W-1:0] push_pc,
   output logic         valid,
   output logic [W-1:0] head_instr,
   output logic [W-1:0] head_pc,
   output logic [1:0]   count
);

   logic [W-1:0] instr_q [2];
   logic [W-1:0] pc_q    [2];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;

   // Flush wins over push; a pop in the flush cycle is simply absorbed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            instr_q[wr_ptr_q] <= push_instr;
            pc_q[wr_ptr_q]    <= push_pc;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

   assign valid      = (count_q != 2'd0);
   assign head_instr = instr_q[rd_ptr_q];
   assign head_pc    = pc_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC generation, single in-flight IMEM read, 2-deep output buffer, redirects.
// Optional build macro FETCH_HALT_ON_ZERO_EN: a fetched all-zero word halts fetching until a redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] issued_pc_q;
   logic            pending_q;
   logic            pop;
   logic            redirect;
   logic            push_ok;
   logic            push;
   logic            credit_ok;
   logic [1:0]      fifo_count;
   logic [2:0]      in_use;

   assign pop      = out_valid & out_ready;
   assign redirect = redirect_valid & (state_q != FETCH_IDLE);
   // The response landing in a redirect cycle belongs to the old path and is dropped with the flush.
   assign push_ok  = pending_q & ~redirect & (state_q == FETCH_RUN);
   assign in_use   = 3'(fifo_count) + 3'(pending_q) - 3'(pop);
   assign credit_ok = (in_use < 3'(DEPTH));

`ifdef FETCH_HALT_ON_ZERO_EN
   logic zero_word;
   logic halt_hit;
   assign zero_word = (imem_rdata == '0);
   assign push      = push_ok & ~zero_word;
   assign halt_hit  = push_ok & zero_word;
`else
   assign push      = push_ok;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_IDLE: state_d = FETCH_RUN;
`ifdef FETCH_HALT_ON_ZERO_EN
         FETCH_RUN:  if (halt_hit) state_d = FETCH_HALT;
         FETCH_HALT: if (redirect) state_d = FETCH_RUN;
`else
         FETCH_RUN:  state_d = FETCH_RUN;
`endif
         default:    state_d = FETCH_IDLE;
      endcase
   end

   // IMEM request: a redirect bypasses the credit check since the buffer is being flushed
   always_comb begin
      imem_en   = 1'b0;
      imem_addr = pc_q;
      if (redirect) begin
         imem_en   = 1'b1;
         imem_addr = redirect_pc & ~XLEN'(3);
      end else if ((state_q == FETCH_RUN) && credit_ok) begin
         imem_en   = 1'b1;
      end
   end

   // PC and in-flight tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         issued_pc_q <= RESET_PC;
         pending_q   <= 1'b0;
      end else begin
         pending_q <= imem_en;
         if (imem_en) begin
            pc_q        <= imem_addr + XLEN'(PC_INC);
            issued_pc_q <= imem_addr;
         end
      end
   end

   fetch_fifo #(
      .W (XLEN)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (redirect),
      .push_instr (imem_rdata),
      .push_pc    (issued_pc_q),
      .valid      (out_valid),
      .head_instr (out_instr),
      .head_pc    (out_pc),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios queue expected {instr, pc}; a monitor checks each handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'hdead_beef;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0231_00b3;
         32'h4:   return 32'h0241_8133;
         32'h8:   return 32'h0252_01b3;
         default: return 32'h0;
      endcase
   endfunction

   // One-cycle registered IMEM
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= rom(imem_addr);
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic expect_item(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      exp_q.push_back(e);
   endtask

   task automatic expect_stream();
      expect_item(32'h0231_00b3, 32'h0);
      expect_item(32'h0241_8133, 32'h4);
      expect_item(32'h0252_01b3, 32'h8);
   endtask

   // Monitor: every accepted output must match the head of the expectation queue
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got pc %h instr %h expected no output", out_pc, out_instr);
         end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_instr", out_instr, e.instr);
         end
      end
      if (rst_n && dut.push) begin
         checks++;
         if (dut.fifo_count == 2'd2) begin
            failures++;
            $display("FAIL push_into_full: got count %0d expected below 2", dut.fifo_count);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imem_en"}, 32'(imem_en), 32'd0);
      check({tag, "_imem_addr"}, imem_addr, 32'h0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_instr"}, out_instr, 32'h0);
      check({tag, "_out_pc"}, out_pc, 32'h0);
   endtask

   task automatic check_drained(input string name);
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      // Basic stream from reset
      out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) cyc();
      settle();
      check_reset_outputs("rst");
      expect_stream();
      rst_n = 1'b1;
      settle();
      check("idle_en", 32'(imem_en), 32'd0);
      cyc(); settle();
      check("c1_en", 32'(imem_en), 32'd1);
      check("c1_addr", imem_addr, 32'h0);
      cyc(); settle();
      check("c2_addr", imem_addr, 32'h4);
      check("c2_out_valid", 32'(out_valid), 32'd0);
      cyc(); settle();
      check("c3_out_valid", 32'(out_valid), 32'd1);
      cyc(); cyc(); cyc();
      out_ready = 1'b0;
      settle();
`ifdef FETCH_HALT_ON_ZERO_EN
      check("halt_out_valid", 32'(out_valid), 32'd0);
      check("halt_en", 32'(imem_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(); settle();
         check("halt_en_hold", 32'(imem_en), 32'd0);
      end
      cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0;
      out_ready = 1'b1;
      expect_stream();
      settle();
      check("resume_en", 32'(imem_en), 32'd1);
      check("resume_addr", imem_addr, 32'h0);
      cyc();
      redirect_valid = 1'b0;
      repeat (6) cyc();
      settle();
      check("rehalt_en", 32'(imem_en), 32'd0);
      check("rehalt_out_valid", 32'(out_valid), 32'd0);
`else
      check("zero_out_valid", 32'(out_valid), 32'd1);
      check("zero_out_pc", out_pc, 32'hc);
      check("zero_out_instr", out_instr, 32'h0);
`endif
      check_drained("basic_drained");

      // Backpressure: decode stalls for five cycles after the first valid
      out_ready = 1'b0;
      do_reset();
      expect_stream();
      rst_n = 1'b1;
      repeat (3) cyc();
      settle();
      check("bp_c3_out_valid", 32'(out_valid), 32'd1);
      for (int i = 4; i <= 7; i++) begin
         cyc(); settle();
         check("bp_full_en", 32'(imem_en), 32'd0);
         check("bp_count", 32'(dut.fifo_count), 32'd2);
      end
      cyc();
      out_ready = 1'b1;
      settle();
      check("bp_release_en", 32'(imem_en), 32'd1);
      check("bp_release_addr", imem_addr, 32'h8);
      cyc(); cyc(); cyc();
      out_ready = 1'b0;
      settle();
      check_drained("bp_drained");

      // Redirect to 0x9 with an entry buffered and a read in flight
      do_reset();
      expect_item(32'h0252_01b3, 32'h8);
      rst_n = 1'b1;
      repeat (3) cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'h9;
      settle();
      check("redir_en", 32'(imem_en), 32'd1);
      check("redir_addr", imem_addr, 32'h8);
      cyc();
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      settle();
      check("redir_flushed", 32'(out_valid), 32'd0);
      cyc(); settle();
      check("redir_out_valid", 32'(out_valid), 32'd1);
      cyc();
      out_ready = 1'b0;
      settle();
      check_drained("redir_drained");

      // Back-to-back redirects: 0x4 then 0x0
      do_reset();
      expect_stream();
      rst_n = 1'b1;
      repeat (3) cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'h4;
      settle();
      check("b2b_addr1", imem_addr, 32'h4);
      cyc();
      redirect_pc = 32'h0;
      settle();
      check("b2b_en2", 32'(imem_en), 32'd1);
      check("b2b_addr2", imem_addr, 32'h0);
      cyc();
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      settle();
      check("b2b_out_valid", 32'(out_valid), 32'd0);
      repeat (4) cyc();
      out_ready = 1'b0;
      settle();
      check_drained("b2b_drained");

      // Reset pulsed mid-stream
      out_ready = 1'b1;
      do_reset();
      expect_item(32'h0231_00b3, 32'h0);
      expect_item(32'h0241_8133, 32'h4);
      rst_n = 1'b1;
      repeat (5) cyc();
      rst_n = 1'b0;
      settle();
      check_reset_outputs("midrst");
      check_drained("midrst_pre_drained");
      cyc();
      expect_stream();
      rst_n = 1'b1;
      cyc(); settle();
      check("midrst_c1_en", 32'(imem_en), 32'd1);
      check("midrst_c1_addr", imem_addr, 32'h0);
      repeat (5) cyc();
      out_ready = 1'b0;
      settle();
      check_drained("midrst_drained");

`ifndef FETCH_HALT_ON_ZERO_EN
      // PC wrap across the top of the address space
      do_reset();
      expect_item(32'h0, 32'hffff_fffc);
      expect_item(32'h0231_00b3, 32'h0);
      rst_n = 1'b1;
      repeat (3) cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'hffff_fffe;
      settle();
      check("wrap_addr", imem_addr, 32'hffff_fffc);
      cyc();
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      cyc(); cyc(); cyc();
      out_ready = 1'b0;
      settle();
      check_drained("wrap_drained");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
